// File: rtl/mdio_master.sv
// MDIO/SMI management master: serialises Clause 22 / Clause 45 frames on MDC/MDIO
// and returns one response per command, with read data and a no-PHY flag.
module mdio_master #(
  parameter int CLK_DIV      = 50,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c22,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  input  logic        md_in,
  output logic        md_out,
  output logic        md_en,
  output logic        md_c
);

  localparam int              CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [5:0]      PRE_LAST  = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [5:0]      HDR_LAST  = 6'd13;
  localparam logic [5:0]      TA_LAST   = 6'd1;
  localparam logic [5:0]      DATA_LAST = 6'd15;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     bit_q, bit_d;
  logic [31:0]    tx_q, tx_d;
  logic [15:0]    rx_q, rx_d;
  logic           rd_q, rd_d;
  logic           ta_err_q, ta_err_d;
  logic [15:0]    rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           md_out_q, md_out_d;
  logic           md_en_q, md_en_d;
  logic           md_c_q, md_c_d;
  logic           bit_end;
  logic           in_frame;

  always_comb begin
    // NOTE: every _d gets its default first, so no path through this block can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_d       = rd_q;
    ta_err_d   = ta_err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    bit_end    = (cnt_q == CNT_LAST);
    in_frame   = state_q inside {S_PRE, S_HDR, S_TA, S_DATA};

    if (in_frame) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rd_d     = cmd_op[1];
          // Read frames carry ones after REGAD so md_out idles high once released.
          tx_d     = {cmd_c22 ? 2'b01 : 2'b00, cmd_op, cmd_phyad, cmd_regad,
                      cmd_op[1] ? 18'h3ffff : {2'b10, cmd_wdata}};
          cnt_d    = '0;
          bit_d    = '0;
          ta_err_d = 1'b0;
          state_d  = (PREAMBLE_LEN == 0) ? S_HDR : S_PRE;
        end
      end
      S_PRE: begin
        if (bit_end) begin
          bit_d = (bit_q == PRE_LAST) ? '0 : bit_q + 6'd1;
          if (bit_q == PRE_LAST) state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (bit_end) begin
          tx_d  = {tx_q[30:0], 1'b1};
          bit_d = (bit_q == HDR_LAST) ? '0 : bit_q + 6'd1;
          if (bit_q == HDR_LAST) state_d = S_TA;
        end
      end
      S_TA: begin
        if (bit_end) begin
          tx_d  = {tx_q[30:0], 1'b1};
          bit_d = (bit_q == TA_LAST) ? '0 : bit_q + 6'd1;
          if (bit_q == TA_LAST) begin
            ta_err_d = md_in;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          tx_d  = {tx_q[30:0], 1'b1};
          rx_d  = {rx_q[14:0], md_in};
          bit_d = (bit_q == DATA_LAST) ? '0 : bit_q + 6'd1;
          if (bit_q == DATA_LAST) begin
            rsp_data_d = rd_q ? rx_d : 16'h0000;
            rsp_err_d  = rd_q & ta_err_q;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pad outputs are registered from next-state values so they change exactly on bit starts.
    rsp_valid_d = (state_d == S_DONE);
    md_c_d      = (state_d inside {S_PRE, S_HDR, S_TA, S_DATA}) && (cnt_d >= CNT_HALF);
    md_en_d     = (state_d inside {S_PRE, S_HDR}) ||
                  ((state_d inside {S_TA, S_DATA}) && !rd_d);
    md_out_d    = (state_d inside {S_HDR, S_TA, S_DATA}) ? tx_d[31] : 1'b1;
  end

  // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '1;
      rx_q        <= '0;
      rd_q        <= 1'b0;
      ta_err_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      md_out_q    <= 1'b1;
      md_en_q     <= 1'b0;
      md_c_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_q        <= rd_d;
      ta_err_q    <= ta_err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      md_out_q    <= md_out_d;
      md_en_q     <= md_en_d;
      md_c_q      <= md_c_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign md_out    = md_out_q;
  assign md_en     = md_en_q;
  assign md_c      = md_c_q;

endmodule
